// File: rtl/sixteen_bit_1_to_8_demux_bank.sv
// Bank of eight 16-bit registers written through a 1-to-8 demux, with a
// sequential clear sweep. The registered entries feed the inputs of an 8-to-1 mux.
module sixteen_bit_1_to_8_demux_bank #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_sel,
  input  logic [15:0] wr_data,
  output logic        wr_done,
  input  logic        clr_req,
  output logic        busy,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7
);

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   clr_idx_q, clr_idx_d;
  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic            wr_done_q, wr_done_d;

  // Next state: a clear request wins over a write; the sweep clears one entry per cycle
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_d     = mem_q;
    wr_done_d = 1'b0;
    wr_ready  = (state_q == IDLE) && !clr_req;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (wr_valid) begin
          mem_d[wr_sel] = wr_data;
          wr_done_d     = 1'b1;
        end
      end
      CLEAR: begin
        mem_d[clr_idx_q] = RESET_VAL;
        clr_idx_d        = clr_idx_q + IW'(1);
        if (clr_idx_q == IW'(NREG - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // State, counter and register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      wr_done_q <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_done_q <= wr_done_d;
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign wr_done = wr_done_q;
  assign busy    = (state_q == CLEAR);

  assign out0 = mem_q[0];
  assign out1 = mem_q[1];
  assign out2 = mem_q[2];
  assign out3 = mem_q[3];
  assign out4 = mem_q[4];
  assign out5 = mem_q[5];
  assign out6 = mem_q[6];
  assign out7 = mem_q[7];

endmodule

// File: tb/tb_sixteen_bit_1_to_8_demux_bank.sv
// Scoreboard bench for the demux register bank: expected writes are queued by the
// stimulus and checked by a monitor on every wr_done; other behaviour is checked inline.
module tb_sixteen_bit_1_to_8_demux_bank;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        clr_req;
  logic        busy;
  logic [7:0][15:0] out_w;

  logic [15:0] exp_mem [8];
  wr_exp_t     sb_q [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          done_cnt = 0;

  sixteen_bit_1_to_8_demux_bank #(.RESET_VAL(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .clr_req  (clr_req),
    .busy     (busy),
    .out0     (out_w[0]),
    .out1     (out_w[1]),
    .out2     (out_w[2]),
    .out3     (out_w[3]),
    .out4     (out_w[4]),
    .out5     (out_w[5]),
    .out6     (out_w[6]),
    .out7     (out_w[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_out%0d", tag, i), 32'(out_w[i]), 32'(exp_mem[i]));
    end
  endtask

  // Accepted write: queue the expectation, update the model, advance one edge
  task automatic do_write(input logic [2:0] sel, input logic [15:0] data);
    wr_exp_t e;
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    e.sel    = sel;
    e.data   = data;
    sb_q.push_back(e);
    exp_mem[sel] = data;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: every wr_done must match a queued write and show its data
  always @(negedge clk) begin
    if (rst_n && wr_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_wr_done: got 1 expected 0 at %0t", $time);
      end else begin
        wr_exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("sb_out%0d", e.sel), 32'(out_w[e.sel]), 32'(e.data));
        done_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_sel = 3'd0; wr_data = 16'h0; clr_req = 1'b0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_done", 32'(wr_done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(wr_ready), 32'd1);

    // Ascending pattern on eight consecutive edges
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'(16'h1111 * (i + 1)));
    step();
    chk("asc_done_cnt", 32'(done_cnt), 32'd8);
    chk("asc_done_low", 32'(wr_done), 32'd0);
    chk_all("asc");

    // Back-to-back overwrite of index 3
    do_write(3'd3, 16'hAAAA);
    do_write(3'd3, 16'h5555);
    step();
    chk_all("ovw");

    // Clear sweep, with an ignored write and an ignored clr_req while busy
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("clr_busy%0d", k), 32'(busy), 32'd1);
      if (k == 2) begin
        wr_valid = 1'b1; wr_sel = 3'd5; wr_data = 16'hFFFF;
      end
      if (k == 4) clr_req = 1'b1;
      #1;
      chk($sformatf("clr_ready%0d", k), 32'(wr_ready), 32'd0);
      step();
      wr_valid = 1'b0;
      clr_req  = 1'b0;
      exp_mem[k] = 16'h0000;
      chk($sformatf("clr_out%0d", k), 32'(out_w[k]), 32'h0);
      if (k < 7) chk($sformatf("clr_hold%0d", k + 1), 32'(out_w[k + 1]), 32'(exp_mem[k + 1]));
      if (k == 2) chk("clr_ign_out5", 32'(out_w[5]), 32'h6666);
    end
    chk("clr_busy_end", 32'(busy), 32'd0);
    chk("clr_ready_end", 32'(wr_ready), 32'd1);
    chk_all("clr");

    // Simultaneous clr_req and write: clear wins
    do_write(3'd2, 16'h3333);
    clr_req = 1'b1; wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'hBEEF;
    #1;
    chk("sim_ready", 32'(wr_ready), 32'd0);
    step();
    clr_req = 1'b0; wr_valid = 1'b0;
    chk("sim_busy", 32'(busy), 32'd1);
    chk("sim_no_write", 32'(out_w[2]), 32'h3333);
    chk("sim_no_done", 32'(wr_done), 32'd0);
    repeat (8) step();
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
    chk("sim_busy_end", 32'(busy), 32'd0);
    chk("sim_out2", 32'(out_w[2]), 32'h0);

    // Reset in the 4th CLEAR cycle, then a normal write
    do_write(3'd6, 16'h7777);
    do_write(3'd7, 16'h9999);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_out6_held", 32'(out_w[6]), 32'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
    chk_all("rst_mid");
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(wr_done), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(wr_ready), 32'd1);
    do_write(3'd6, 16'h1234);
    chk("rst_rel_out6", 32'(out_w[6]), 32'h1234);
    step();
    chk_all("final");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_1_to_8_demux_bank.md
SIXTEEN_BIT_1_TO_8_DEMUX_BANK -- requirements
Module: sixteen_bit_1_to_8_demux_bank

Interface
REQ-001 Parameter: RESET_VAL, 16'h0000, value loaded into every register on reset and on clear.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 wr_valid  input  1  write request qualifier.
REQ-005 wr_ready  output  1  block can accept a write this cycle.
REQ-006 wr_sel  input  3  destination register index, 0..7.
REQ-007 wr_data  input  16  write data.
REQ-008 wr_done  output  1  one-cycle pulse confirming a completed write.
REQ-009 clr_req  input  1  request a sequential clear of all eight registers.
REQ-010 busy  output  1  high while a clear sweep is in progress.
REQ-011 out0..out7  output  16 each  registered contents of entries 0..7; these feed the 16-bit 8-to-1 mux inputs in0..in7.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and CLEAR, plus a 3-bit clear counter clr_idx.
REQ-013 wr_ready SHALL be combinational: 1 when state==IDLE and clr_req==0, else 0.
REQ-014 A write SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1.
REQ-015 On acceptance, only out[wr_sel] SHALL take wr_data; the other seven outputs hold.
REQ-016 Write latency: new data SHALL be visible on out[wr_sel] immediately after the accepting edge.
REQ-017 wr_done SHALL be registered, high for exactly the one cycle following each accepting edge, and low otherwise.
REQ-018 Back-to-back accepted writes on consecutive edges SHALL all take effect.
REQ-019 A later write to the same index SHALL overwrite the earlier one.
REQ-020 wr_valid while wr_ready==0 SHALL be ignored: no register change and no wr_done.
REQ-021 clr_req==1 in IDLE SHALL move the FSM to CLEAR on the next edge, with clr_idx=0.
REQ-022 clr_req SHALL take priority over a simultaneous wr_valid; that write is not accepted.
REQ-023 In CLEAR, each edge SHALL load RESET_VAL into out[clr_idx] and increment clr_idx.
REQ-024 On the edge that clears index 7, the FSM SHALL return to IDLE and clr_idx SHALL wrap to 0.
REQ-025 A full sweep SHALL therefore take exactly 8 cycles in CLEAR.
REQ-026 busy SHALL equal (state==CLEAR).
REQ-027 clr_req asserted while in CLEAR SHALL be ignored and SHALL NOT restart or extend the sweep.
REQ-028 A clr_req still high on return to IDLE SHALL start a new sweep on the following edge.
REQ-029 wr_sel SHALL be fully decoded: all 8 codes are valid, and no code writes more than one register.

Reset
REQ-030 While rst_n==0, the block SHALL asynchronously force:
- out0..out7 = RESET_VAL
- state = IDLE, clr_idx = 0
- wr_done = 0, busy = 0
REQ-031 Reset asserted mid-sweep or mid-write SHALL abort the operation with no partial state surviving.
REQ-032 After rst_n deasserts, the first accepting edge SHALL behave normally, and wr_ready SHALL be 1 provided clr_req==0.

Verification
REQ-033 Ascending write pattern: after reset, write 16'h1111..16'h8888 to wr_sel 0..7 on eight consecutive edges.
- out0..out7 = 16'h1111..16'h8888.
- wr_done high for 8 consecutive cycles.
REQ-034 Overwrite and ignored write:
- Write 16'hAAAA then 16'h5555 to index 3 back-to-back -> out3=16'h5555, other outputs unchanged.
- wr_valid=1 with the block busy -> no change.
REQ-035 Clear sweep: with the ascending pattern loaded, pulse clr_req for one cycle.
- busy high for exactly 8 cycles and wr_ready low throughout.
- out0 cleared on the first CLEAR edge, out7 on the eighth.
- Finally all outputs = 16'h0000.
REQ-036 Simultaneous requests: clr_req=1 and wr_valid=1 (sel 2, 16'hBEEF) on the same cycle.
- No write and no wr_done.
- Sweep starts, and out2 ends at 16'h0000.
REQ-037 Reset mid-sweep: assert rst_n=0 between clock edges during the 4th CLEAR cycle.
- All outputs = RESET_VAL and busy=0 immediately, before the next edge.
- After release, a write of 16'h1234 to index 6 gives out6=16'h1234 one edge later.
